// File: rtl/axi_pkg.sv
// Shared AXI constants and the burst-master FSM state encoding.
//   BURST_INCR     : AXI burst type for incrementing bursts
//   RESP_*         : AXI response codes used by the master
//   CACHE_DEFAULT  : normal non-cacheable bufferable
//   state_t        : burst-master FSM states
package axi_pkg;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_WR_RESP = 3'd2,
    S_READ    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 single-burst initiator. A command (addr, len, write) starts one INCR
// burst; write beats stream in on wr_*, read beats stream out on rd_*, and a
// one-cycle done pulse reports the final response before the next command.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cmd_*                command handshake (addr, len = beats-1, write flag)
//   wr_*                 write beat stream into the burst
//   rd_*                 read beat stream out of the burst (rd_last on final beat)
//   done_*               completion pulse with direction and response
//   m_axi_aw/w/b/ar/r*   AXI4 master port
//   dbg_state            current FSM state
//
// Handshakes: every valid/ready pair transfers on a rising edge where both are
// high; a valid, once raised, holds (with stable payload) until its ready.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  cmd_write,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done_valid,
  output logic                  done_write,
  output logic [1:0]            done_resp,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output state_t                dbg_state
);

  localparam logic [2:0]            AXSIZE    = 3'($clog2(STRB_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MSK = ~ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [ID_WIDTH-1:0]   ID_CONST  = ID_WIDTH'(AXI_ID);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic                  r_write;
  logic [7:0]            r_cnt;
  logic [1:0]            r_resp;
  logic                  r_aw_done;
  logic                  r_ar_done;
  logic                  r_w_done;   // last W beat sent while AW still pending

  logic w_cmd_fire;
  logic w_aw_fire;
  logic w_w_fire;
  logic w_ar_fire;
  logic w_r_fire;
  logic w_cnt_last;
  logic w_unused;

  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_aw_fire  = m_axi_awvalid && m_axi_awready;
  assign w_w_fire   = m_axi_wvalid && m_axi_wready;
  assign w_ar_fire  = m_axi_arvalid && m_axi_arready;
  assign w_r_fire   = m_axi_rvalid && m_axi_rready;
  assign w_cnt_last = (r_cnt == r_len);
  assign w_unused   = ^{m_axi_bid, m_axi_rid};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (cmd_valid) w_next = cmd_write ? S_WRITE : S_READ;
      S_WRITE:   if ((r_w_done || (w_w_fire && w_cnt_last)) &&
                     (r_aw_done || w_aw_fire))
                   w_next = S_WR_RESP;
      S_WR_RESP: if (m_axi_bvalid) w_next = S_DONE;
      S_READ:    if (w_r_fire && w_cnt_last) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready     = (r_state == S_IDLE);
    dbg_state     = r_state;

    m_axi_awid    = ID_CONST;
    m_axi_awaddr  = r_addr;
    m_axi_awlen   = r_len;
    m_axi_awsize  = AXSIZE;
    m_axi_awburst = BURST_INCR;
    m_axi_awlock  = 1'b0;
    m_axi_awcache = CACHE_DEFAULT;
    m_axi_awprot  = 3'b000;
    m_axi_awvalid = (r_state == S_WRITE) && !r_aw_done;

    m_axi_wdata   = wr_data;
    m_axi_wstrb   = wr_strb;
    m_axi_wlast   = w_cnt_last;
    m_axi_wvalid  = (r_state == S_WRITE) && !r_w_done && wr_valid;
    wr_ready      = (r_state == S_WRITE) && !r_w_done && m_axi_wready;

    m_axi_bready  = (r_state == S_WR_RESP);

    m_axi_arid    = ID_CONST;
    m_axi_araddr  = r_addr;
    m_axi_arlen   = r_len;
    m_axi_arsize  = AXSIZE;
    m_axi_arburst = BURST_INCR;
    m_axi_arlock  = 1'b0;
    m_axi_arcache = CACHE_DEFAULT;
    m_axi_arprot  = 3'b000;
    m_axi_arvalid = (r_state == S_READ) && !r_ar_done;

    // R is only opened to the stream once the address phase is accepted
    m_axi_rready  = (r_state == S_READ) && r_ar_done && rd_ready;
    rd_valid      = (r_state == S_READ) && r_ar_done && m_axi_rvalid;
    rd_data       = m_axi_rdata;
    rd_last       = w_cnt_last;

    done_valid    = (r_state == S_DONE);
    done_write    = r_write;
    done_resp     = r_resp;
  end

  // Burst context, beat counter and response tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_write   <= 1'b0;
      r_cnt     <= '0;
      r_resp    <= RESP_OKAY;
      r_aw_done <= 1'b0;
      r_ar_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_addr    <= cmd_addr & ALIGN_MSK;
        r_len     <= cmd_len;
        r_write   <= cmd_write;
        r_cnt     <= '0;
        r_resp    <= RESP_OKAY;
        r_aw_done <= 1'b0;
        r_ar_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_fire) r_aw_done <= 1'b1;
      if (w_ar_fire) r_ar_done <= 1'b1;
      if (w_w_fire) begin
        // len = 255 wraps the counter to 0 after the final beat; harmless
        r_cnt <= r_cnt + 8'd1;
        if (w_cnt_last) r_w_done <= 1'b1;
      end
      if ((r_state == S_WR_RESP) && m_axi_bvalid) r_resp <= m_axi_bresp;
      if (w_r_fire) begin
        r_cnt <= r_cnt + 8'd1;
        // A framing error overrides any earlier slave error code
        if (m_axi_rlast != w_cnt_last)
          r_resp <= RESP_SLVERR;
        else if ((m_axi_rresp != RESP_OKAY) && (r_resp == RESP_OKAY))
          r_resp <= m_axi_rresp;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
module tb_axi_burst_master;
  import axi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        cmd_write = 1'b0, cmd_valid = 1'b0, cmd_ready;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = 4'hF;
  logic        wr_valid = 1'b0, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready = 1'b0;
  logic        done_valid, done_write;
  logic [1:0]  done_resp;
  logic [7:0]  m_axi_awid, m_axi_awlen, m_axi_arid, m_axi_arlen;
  logic [15:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst;
  logic        m_axi_awlock, m_axi_arlock;
  logic [3:0]  m_axi_awcache, m_axi_arcache;
  logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [7:0]  m_axi_bid, m_axi_rid;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [31:0] m_axi_rdata;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  state_t      dbg_state;

  axi_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_write(cmd_write),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done_valid(done_valid), .done_write(done_write), .done_resp(done_resp),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .dbg_state(dbg_state)
  );

  // ---------------- AXI RAM slave model ----------------
  logic [31:0] mem [0:16383];
  int          aw_delay = 0, ar_delay = 0, err_beat = -1, early_last = -1;
  logic [1:0]  b_resp_cfg = 2'b00;
  int          aw_wait, ar_wait, rbeat;
  logic        aw_seen, wl_seen, s_bvalid, r_active;
  logic [15:0] aw_addr_l, ar_addr_l;
  logic [7:0]  ar_len_l;
  logic [31:0] wq[$];
  logic [3:0]  sq[$];
  logic [13:0] r_idx;
  logic [13:0] c_base;
  logic        s_awf, s_wf, s_arf;

  assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
  assign m_axi_arready = m_axi_arvalid && (ar_wait >= ar_delay);
  assign m_axi_wready  = 1'b1;
  assign m_axi_bvalid  = s_bvalid;
  assign m_axi_bresp   = b_resp_cfg;
  assign m_axi_bid     = 8'd0;
  assign m_axi_rid     = 8'd0;
  assign r_idx         = ar_addr_l[15:2] + rbeat[13:0];
  assign m_axi_rvalid  = r_active;
  assign m_axi_rdata   = mem[r_idx];
  assign m_axi_rresp   = (rbeat == err_beat) ? 2'b10 : 2'b00;
  assign m_axi_rlast   = (early_last >= 0) ? (rbeat == early_last) : (rbeat == int'(ar_len_l));

  initial for (int i = 0; i < 16384; i++) mem[i] = 32'h0;

  always @(posedge clk) begin
    s_awf = m_axi_awvalid && m_axi_awready;
    s_wf  = m_axi_wvalid && m_axi_wready;
    s_arf = m_axi_arvalid && m_axi_arready;
    if (rst) begin
      aw_seen <= 1'b0; wl_seen <= 1'b0; s_bvalid <= 1'b0; r_active <= 1'b0;
      aw_wait <= 0; ar_wait <= 0; rbeat <= 0; aw_addr_l <= '0; ar_addr_l <= '0; ar_len_l <= '0;
      wq.delete(); sq.delete();
    end else begin
      if (s_awf) begin
        aw_seen <= 1'b1; aw_addr_l <= m_axi_awaddr; aw_wait <= 0;
      end else if (m_axi_awvalid) aw_wait <= aw_wait + 1;
      if (s_wf) begin
        wq.push_back(m_axi_wdata); sq.push_back(m_axi_wstrb);
      end
      if (s_bvalid && m_axi_bready) s_bvalid <= 1'b0;
      if ((aw_seen || s_awf) && (wl_seen || (s_wf && m_axi_wlast)) && !s_bvalid) begin
        c_base = s_awf ? m_axi_awaddr[15:2] : aw_addr_l[15:2];
        for (int i = 0; i < wq.size(); i++)
          for (int b = 0; b < 4; b++)
            if (sq[i][b]) mem[c_base + 14'(i)][8*b +: 8] = wq[i][8*b +: 8];
        wq.delete(); sq.delete();
        s_bvalid <= 1'b1; aw_seen <= 1'b0; wl_seen <= 1'b0;
      end else if (s_wf && m_axi_wlast) wl_seen <= 1'b1;
      if (s_arf) begin
        ar_addr_l <= m_axi_araddr; ar_len_l <= m_axi_arlen;
        r_active <= 1'b1; rbeat <= 0; ar_wait <= 0;
      end else if (m_axi_arvalid) ar_wait <= ar_wait + 1;
      if (r_active && m_axi_rready) begin
        if (rbeat == int'(ar_len_l)) r_active <= 1'b0;
        rbeat <= rbeat + 1;
      end
    end
  end

  // ---------------- scoreboard / monitors ----------------
  int          tests_run = 0, tests_failed = 0;
  logic [31:0] exp_q[$];
  int          done_cnt = 0;
  logic        d_write;
  logic [1:0]  d_resp;
  int          viol = 0;
  logic        p_aw = 1'b0, p_ar = 1'b0, p_rd = 1'b0;
  logic [31:0] p_rd_data;

  always @(negedge clk) begin
    if (done_valid) begin
      done_cnt++; d_write = done_write; d_resp = done_resp;
    end
  end

  // A valid waiting on ready must stay high (and rd_data stable) next cycle
  always @(posedge clk) begin
    if (rst) begin
      p_aw = 1'b0; p_ar = 1'b0; p_rd = 1'b0;
    end else begin
      if (p_aw && !m_axi_awvalid) viol++;
      if (p_ar && !m_axi_arvalid) viol++;
      if (p_rd && (!rd_valid || rd_data !== p_rd_data)) viol++;
      p_aw = m_axi_awvalid && !m_axi_awready;
      p_ar = m_axi_arvalid && !m_axi_arready;
      p_rd = rd_valid && !rd_ready;
      p_rd_data = rd_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns at the negedge of the cycle after acceptance
  task automatic send_cmd(input logic [15:0] a, input logic [7:0] l, input logic w);
    int t = 0;
    @(negedge clk);
    cmd_addr = a; cmd_len = l; cmd_write = w; cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && t < 100) begin @(negedge clk); #1; t++; end
    check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic stream_write(input int len, input logic [31:0] base);
    int i = 0, t = 0;
    while (i <= len && t < 200) begin
      wr_valid = 1'b1; wr_data = base + i; wr_strb = 4'hF;
      #1;
      if (wr_ready) begin
        check("wlast", {31'd0, m_axi_wlast}, {31'd0, (i == len)});
        i++;
      end
      @(negedge clk); t++;
    end
    wr_valid = 1'b0;
    check("wr_stream_done", i, len + 1);
  endtask

  task automatic read_collect(input int len, input bit toggle);
    int n = 0, t = 0;
    while (n <= len && t < 300) begin
      rd_ready = toggle ? t[0] : 1'b1;
      #1;
      if (rd_valid && rd_ready) begin
        check("rd_data", rd_data, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD);
        check("rd_last", {31'd0, rd_last}, {31'd0, (n == len)});
        n++;
      end
      @(negedge clk); t++;
    end
    rd_ready = 1'b0;
    check("rd_beats", n, len + 1);
    check("rd_exp_empty", exp_q.size(), 0);
  endtask

  task automatic wait_done(input int prev, input logic w, input logic [1:0] resp);
    int t = 0;
    #2;
    while (done_cnt == prev && t < 200) begin @(negedge clk); #2; t++; end
    check("done_seen", done_cnt, prev + 1);
    check("done_write", {31'd0, d_write}, {31'd0, w});
    check("done_resp", {30'd0, d_resp}, {30'd0, resp});
    @(negedge clk); #1;
    check("done_one_cycle", {31'd0, done_valid}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int prev;
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_valids", {26'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                         m_axi_bready, m_axi_rready, rd_valid}, 32'd0);
    check("rst_done", {28'd0, done_valid, done_write, done_resp}, 32'd0);

    // Minimum write, cycle-exact; unaligned address and partial strobe
    prev = done_cnt;
    @(negedge clk);
    cmd_addr = 16'h0203; cmd_len = 8'd0; cmd_write = 1'b1; cmd_valid = 1'b1;
    wr_valid = 1'b1; wr_data = 32'h11223344; wr_strb = 4'h6;
    #1; check("min_accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk); cmd_valid = 1'b0; #1;
    check("min_awvalid", {31'd0, m_axi_awvalid}, 32'd1);
    check("min_awaddr", {16'd0, m_axi_awaddr}, 32'h0200);
    check("min_aw_fields", {m_axi_awid, m_axi_awlen, 3'd0, m_axi_awsize, m_axi_awburst,
                            m_axi_awlock, m_axi_awcache, m_axi_awprot},
                           {8'd0, 8'd0, 3'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
    check("min_w", {m_axi_wvalid, m_axi_wlast, 2'd0, m_axi_wstrb}, 8'b1100_0110);
    check("min_wdata", m_axi_wdata, 32'h11223344);
    check("min_cmd_busy", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk); wr_valid = 1'b0; wr_strb = 4'hF; #1;
    check("min_bready", {30'd0, m_axi_bready, m_axi_awvalid}, 32'd2);
    @(negedge clk); #1;
    check("min_done", {29'd0, done_valid, done_resp}, 32'h4);
    check("min_done_write", {31'd0, done_write}, 32'd1);
    @(negedge clk); #1;
    check("min_cmd_ready", {30'd0, cmd_ready, done_valid}, 32'd2);
    check("min_mem", mem[14'h80], 32'h00223300);

    // Write len 3 to 0x0100, data A0..A3
    prev = done_cnt;
    send_cmd(16'h0100, 8'd3, 1'b1);
    stream_write(3, 32'hA0);
    wait_done(prev, 1'b1, 2'b00);
    for (int i = 0; i < 4; i++) check("wr_mem", mem[14'h40 + 14'(i)], 32'hA0 + i);

    // Read len 3 back
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
    prev = done_cnt;
    send_cmd(16'h0100, 8'd3, 1'b0);
    check("ar_fields", {m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize},
                       {1'b1, 16'h0100, 8'd3, 3'd2});
    read_collect(3, 1'b0);
    wait_done(prev, 1'b0, 2'b00);

    // Read with backpressure and slow address channel
    aw_delay = 5; ar_delay = 5;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
    prev = done_cnt;
    send_cmd(16'h0100, 8'd3, 1'b0);
    read_collect(3, 1'b1);
    wait_done(prev, 1'b0, 2'b00);

    // Write whose W beats finish before AW is accepted
    prev = done_cnt;
    send_cmd(16'h0500, 8'd1, 1'b1);
    stream_write(1, 32'hD0);
    wait_done(prev, 1'b1, 2'b00);
    check("slow_aw_mem0", mem[14'h140], 32'hD0);
    check("slow_aw_mem1", mem[14'h141], 32'hD1);
    aw_delay = 0; ar_delay = 0;

    // rresp error on beat 2 of 4
    err_beat = 1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
    prev = done_cnt;
    send_cmd(16'h0100, 8'd3, 1'b0);
    read_collect(3, 1'b0);
    wait_done(prev, 1'b0, 2'b10);
    err_beat = -1;

    // Early rlast on beat 2 of len 3
    early_last = 1;
    prev = done_cnt;
    send_cmd(16'h0100, 8'd3, 1'b0);
    rd_ready = 1'b1;
    wait_done(prev, 1'b0, 2'b10);
    rd_ready = 1'b0;
    early_last = -1;

    // Write with an error B response
    b_resp_cfg = 2'b10;
    prev = done_cnt;
    send_cmd(16'h0600, 8'd0, 1'b1);
    stream_write(0, 32'hE0);
    wait_done(prev, 1'b1, 2'b10);
    b_resp_cfg = 2'b00;

    // Reset during beat 2 of a len 7 write
    prev = done_cnt;
    send_cmd(16'h0400, 8'd7, 1'b1);
    wr_valid = 1'b1; wr_data = 32'hB0;
    @(negedge clk);
    wr_data = 32'hB1; rst = 1'b1;
    @(negedge clk); #1;
    check("mid_rst_state", {30'd0, cmd_ready, done_valid}, 32'd2);
    check("mid_rst_valids", {28'd0, m_axi_awvalid, m_axi_wvalid, wr_ready, m_axi_bready}, 32'd0);
    rst = 1'b0; wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", done_cnt, prev);
    check("mid_rst_mem", mem[14'h100], 32'h0);
    prev = done_cnt;
    send_cmd(16'h0300, 8'd1, 1'b1);
    stream_write(1, 32'hC0);
    wait_done(prev, 1'b1, 2'b00);
    check("post_rst_mem0", mem[14'hC0], 32'hC0);
    check("post_rst_mem1", mem[14'hC1], 32'hC1);

    check("valid_stability", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
